branch_target_predictor: RTL and testbench

Parametrised branch predictor for the pipelined MIPS core. It replaces the fixed 16-entry, index-only predictor with a direct-mapped branch target buffer that adds partial tags, valid bits, configurable saturating counters, bulk invalidate and saturating statistics counters. Lookup is combinational from the fetch-stage PC. Updates come from the stage that resolves branches (EX/MEM), one per cycle.

---
 rtl/bp_pkg.sv | 35 +++
 rtl/bp_sat_counter.sv | 35 +++
 rtl/branch_target_predictor.sv | 138 +++++++++++++
 tb/tb_branch_target_predictor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target predictor: PC field extraction and saturating arithmetic.
// Pure functions; no state, no latency, no flow control.
package bp_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned IDX_MAX_W = 8;
  localparam int unsigned TAG_MAX_W = 30;

  // Word-aligned index: the two byte-offset bits never select an entry.
  function automatic logic [IDX_MAX_W-1:0] bp_index(word_t pc, int unsigned idx_w);
    word_t mask;
    word_t v;
    mask = (word_t'(1) << idx_w) - word_t'(1);
    v    = (pc >> 2) & mask;
    return v[IDX_MAX_W-1:0];
  endfunction

  function automatic logic [TAG_MAX_W-1:0] bp_tag(word_t pc, int unsigned idx_w, int unsigned tag_w);
    word_t mask;
    word_t v;
    mask = (word_t'(1) << tag_w) - word_t'(1);
    v    = (pc >> (idx_w + 2)) & mask;
    return v[TAG_MAX_W-1:0];
  endfunction

  function automatic word_t sat_inc(word_t v, word_t max);
    return (v >= max) ? max : v + word_t'(1);
  endfunction

  function automatic word_t sat_dec(word_t v);
    return (v == '0) ? '0 : v - word_t'(1);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic for a W-bit saturating counter with increment, decrement and load.
// Combinational; the caller owns the register. Load has priority; inc and dec together hold.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] cur_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] nxt_o
);

  localparam word_t MAX = word_t'({W{1'b1}});

  word_t cur_ext;
  word_t res;

  always_comb begin
    cur_ext = word_t'(cur_i);
    res     = cur_ext;
    if (load_i) begin
      res = word_t'(load_val_i);
    end else if (inc_i && !dec_i) begin
      res = sat_inc(cur_ext, MAX);
    end else if (dec_i && !inc_i) begin
      res = sat_dec(cur_ext);
    end
  end

  assign nxt_o = res[W-1:0];

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with partial tags and saturating direction counters; lookup is combinational,
// updates land on the next rising CLK edge (one per cycle, never stalls). Saturating branch/mispredict stats.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned STAT_W  = 32,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  word_t             lookup_pc,
  output logic              hit,
  output logic              predict_taken,
  output word_t             predict_target,
  output logic [IDX_W-1:0]  pred_index,
  input  logic              upd_valid,
  input  word_t             upd_pc,
  input  logic              upd_taken,
  input  word_t             upd_target,
  input  logic              upd_mispredict,
  input  logic              invalidate,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam logic [CNT_W-1:0] CNT_WEAK_TAKEN = CNT_W'(1) << (CNT_W - 1);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  word_t             target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  logic [STAT_W-1:0] br_q, br_d;
  logic [STAT_W-1:0] mp_q, mp_d;

  // Lookup side
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = IDX_W'(bp_index(lookup_pc, IDX_W));
  assign lk_tag = TAG_W'(bp_tag(lookup_pc, IDX_W, TAG_W));
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign hit            = lk_hit;
  assign predict_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1];
  assign predict_target = lk_hit ? target_q[lk_idx] : '0;
  assign pred_index     = lk_idx;

  // Update side
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_alloc;
  logic             ent_we;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_d;

  assign up_idx = IDX_W'(bp_index(upd_pc, IDX_W));
  assign up_tag = TAG_W'(bp_tag(upd_pc, IDX_W, TAG_W));

  always_comb begin
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    cnt_cur  = cnt_q[up_idx];
    up_alloc = !up_hit && upd_taken;
    // A not-taken miss leaves the entry alone; invalidate drops the write entirely.
    ent_we   = upd_valid && !invalidate && (up_hit || upd_taken);
  end

  bp_sat_counter #(.W(CNT_W)) u_entry_cnt (
    .cur_i      (cnt_cur),
    .inc_i      (up_hit && upd_taken),
    .dec_i      (up_hit && !upd_taken),
    .load_i     (up_alloc),
    .load_val_i (CNT_WEAK_TAKEN),
    .nxt_o      (cnt_d)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else if (invalidate) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (ent_we) begin
      cnt_q[up_idx] <= cnt_d;
      if (upd_taken) begin
        target_q[up_idx] <= upd_target;
      end
      if (up_alloc) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
      end
    end
  end

  // Statistics count every resolved branch, even one whose entry write was dropped by invalidate.
  bp_sat_counter #(.W(STAT_W)) u_stat_br (
    .cur_i      (br_q),
    .inc_i      (upd_valid),
    .dec_i      (1'b0),
    .load_i     (1'b0),
    .load_val_i ('0),
    .nxt_o      (br_d)
  );

  bp_sat_counter #(.W(STAT_W)) u_stat_mp (
    .cur_i      (mp_q),
    .inc_i      (upd_valid && upd_mispredict),
    .dec_i      (1'b0),
    .load_i     (1'b0),
    .load_val_i ('0),
    .nxt_o      (mp_d)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed scenarios with literal expectations plus a randomized
// run compared every cycle against an array-based model of the predictor's rules.
module tb_branch_target_predictor;

  localparam int ENT  = 16;
  localparam int TW   = 8;
  localparam int CW   = 2;
  localparam int SW   = 4;
  localparam int IW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int SMAX = (1 << SW) - 1;

  logic          CLK;
  logic          nRST;
  logic [31:0]   lookup_pc;
  logic          hit;
  logic          predict_taken;
  logic [31:0]   predict_target;
  logic [IW-1:0] pred_index;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic          upd_taken;
  logic [31:0]   upd_target;
  logic          upd_mispredict;
  logic          invalidate;
  logic [SW-1:0] stat_branches;
  logic [SW-1:0] stat_mispredicts;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  int          m_valid [ENT];
  int unsigned m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_cnt   [ENT];
  int          m_br;
  int          m_mp;

  branch_target_predictor #(
    .ENTRIES (ENT),
    .TAG_W   (TW),
    .CNT_W   (CW),
    .STAT_W  (SW)
  ) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .lookup_pc        (lookup_pc),
    .hit              (hit),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .pred_index       (pred_index),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .invalidate       (invalidate),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < ENT; k++) begin
      m_valid[k] = 0;
      m_tag[k]   = 0;
      m_tgt[k]   = '0;
      m_cnt[k]   = 0;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic model_step();
    int          i;
    int unsigned t;
    if (upd_valid) begin
      if (m_br < SMAX) m_br++;
      if (upd_mispredict && m_mp < SMAX) m_mp++;
      if (!invalidate) begin
        i = int'((upd_pc / 4) % ENT);
        t = (upd_pc / (4 * ENT)) % (1 << TW);
        if (m_valid[i] != 0 && m_tag[i] == t) begin
          if (upd_taken) begin
            if (m_cnt[i] < CMAX) m_cnt[i]++;
            m_tgt[i] = upd_target;
          end else if (m_cnt[i] > 0) begin
            m_cnt[i]--;
          end
        end else if (upd_taken) begin
          m_valid[i] = 1;
          m_tag[i]   = t;
          m_tgt[i]   = upd_target;
          m_cnt[i]   = 1 << (CW - 1);
        end
      end
    end
    if (invalidate) begin
      for (int k = 0; k < ENT; k++) m_valid[k] = 0;
    end
  endtask

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) model_reset();
    else       model_step();
  end

  task automatic compare_all();
    int          i;
    int unsigned t;
    bit          eh;
    bit          ep;
    logic [31:0] et;
    i  = int'((lookup_pc / 4) % ENT);
    t  = (lookup_pc / (4 * ENT)) % (1 << TW);
    eh = (m_valid[i] != 0) && (m_tag[i] == t);
    ep = eh && (m_cnt[i] >= (1 << (CW - 1)));
    et = eh ? m_tgt[i] : 32'h0;
    check("m_hit",      32'(hit),              32'(eh));
    check("m_taken",    32'(predict_taken),    32'(ep));
    check("m_target",   predict_target,        et);
    check("m_index",    32'(pred_index),       32'(i));
    check("m_stat_br",  32'(stat_branches),    32'(m_br));
    check("m_stat_mp",  32'(stat_mispredicts), 32'(m_mp));
  endtask

  always @(negedge CLK) begin
    if (chk_en) compare_all();
  end

  // Drives one update that lands on the next rising edge, then returns just after that edge.
  task automatic do_upd(logic [31:0] pc, logic taken, logic [31:0] tgt, logic mp);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = taken;
    upd_target     = tgt;
    upd_mispredict = mp;
    @(posedge CLK);
    #1;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    if ($urandom_range(0, 7) == 0) p = $urandom();
    else p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
    return p;
  endfunction

  initial begin
    nRST           = 1'b1;
    lookup_pc      = 32'h40;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_taken      = 1'b0;
    upd_target     = '0;
    upd_mispredict = 1'b0;
    invalidate     = 1'b0;
    model_reset();
    #1 nRST = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_hit",    32'(hit),              32'h0);
    check("rst_taken",  32'(predict_taken),    32'h0);
    check("rst_target", predict_target,        32'h0);
    check("rst_index",  32'(pred_index),       32'h0);
    check("rst_br",     32'(stat_branches),    32'h0);
    check("rst_mp",     32'(stat_mispredicts), 32'h0);
    @(posedge CLK);
    #3 nRST = 1'b1;
    @(posedge CLK);
    #1;

    do_upd(32'h40, 1'b1, 32'h100, 1'b1);
    check("alloc_hit",    32'(hit),              32'h1);
    check("alloc_taken",  32'(predict_taken),    32'h1);
    check("alloc_target", predict_target,        32'h100);
    check("alloc_br",     32'(stat_branches),    32'h1);
    check("alloc_mp",     32'(stat_mispredicts), 32'h1);

    lookup_pc = 32'h80;
    #1;
    check("alias_hit",    32'(hit),           32'h0);
    check("alias_target", predict_target,     32'h0);
    check("alias_index",  32'(pred_index),    32'h0);
    lookup_pc = 32'h40;

    repeat (3) do_upd(32'h40, 1'b1, 32'h100, 1'b0);
    check("sat_hi_taken", 32'(predict_taken), 32'h1);
    repeat (2) do_upd(32'h40, 1'b0, 32'h0, 1'b0);
    check("weak_nt_hit",    32'(hit),           32'h1);
    check("weak_nt_taken",  32'(predict_taken), 32'h0);
    check("nt_keeps_tgt",   predict_target,     32'h100);
    repeat (2) do_upd(32'h40, 1'b0, 32'h0, 1'b0);
    do_upd(32'h40, 1'b1, 32'h104, 1'b0);
    check("sat_lo_taken", 32'(predict_taken), 32'h0);
    check("retarget",     predict_target,     32'h104);
    do_upd(32'h40, 1'b1, 32'h104, 1'b0);
    check("back_taken",   32'(predict_taken), 32'h1);

    upd_valid  = 1'b1;
    upd_pc     = 32'h40;
    upd_taken  = 1'b0;
    upd_target = 32'h0;
    #1;
    check("same_cyc_pre",  32'(predict_taken), 32'h1);
    @(posedge CLK);
    #1 upd_valid = 1'b0;
    check("same_cyc_post", 32'(predict_taken), 32'h0);

    upd_valid  = 1'b1;
    upd_pc     = 32'h200;
    upd_taken  = 1'b1;
    upd_target = 32'h300;
    invalidate = 1'b1;
    @(posedge CLK);
    #1;
    upd_valid  = 1'b0;
    invalidate = 1'b0;
    check("inv_hit",  32'(hit),              32'h0);
    check("inv_br",   32'(stat_branches),    32'd12);
    check("inv_mp",   32'(stat_mispredicts), 32'd1);
    lookup_pc = 32'h200;
    #1;
    check("inv_drop", 32'(hit), 32'h0);

    repeat (20) do_upd(32'h1000, 1'b0, 32'h0, 1'b1);
    check("stat_sat_br", 32'(stat_branches),    32'd15);
    check("stat_sat_mp", 32'(stat_mispredicts), 32'd15);
    do_upd(32'h40, 1'b1, 32'h500, 1'b1);
    check("stat_hold_br", 32'(stat_branches), 32'd15);

    lookup_pc  = 32'h80;
    upd_valid  = 1'b1;
    upd_pc     = 32'h80;
    upd_taken  = 1'b1;
    upd_target = 32'h700;
    #2 nRST = 1'b0;
    @(posedge CLK);
    #1 upd_valid = 1'b0;
    #2 nRST = 1'b1;
    check("rst_mid_hit", 32'(hit),           32'h0);
    check("rst_mid_br",  32'(stat_branches), 32'h0);
    @(posedge CLK);
    #1;

    for (int c = 0; c < 3000; c++) begin
      upd_valid      = ($urandom_range(0, 9) < 6);
      upd_pc         = rand_pc();
      upd_taken      = 1'($urandom_range(0, 1));
      upd_target     = $urandom();
      upd_mispredict = 1'($urandom_range(0, 1));
      invalidate     = ($urandom_range(0, 49) == 0);
      lookup_pc      = ($urandom_range(0, 3) == 0) ? upd_pc : rand_pc();
      if (c % 60 == 59) begin
        #2 nRST = 1'b0;
        #3 nRST = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
    upd_valid  = 1'b0;
    invalidate = 1'b0;
    @(posedge CLK);
    #1;
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
